mips_disp_scan: RTL

MIPS_DISP_SCAN -- requirements
Module: mips_disp_scan

---
 rtl/mips_disp_scan.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mips_disp_scan.sv
// Eight-digit multiplexed hex display for a MIPS core: one debounced button cycles the
// source (PC, Instr, register read, memory read), and each frame latches one coherent word.
module mips_disp_scan #(
   parameter int SCAN_DIV = 50000,
   parameter int DEB_LEN  = 1000000
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] PC,
   input  logic [31:0] Instr,
   input  logic [31:0] DispRegData,
   input  logic [31:0] DispMemData,
   input  logic [3:0]  Stat,
   input  logic        BtnMode,
   output logic [7:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic [1:0]  Mode
);

   localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W  = (DEB_LEN > 2) ? $clog2(DEB_LEN) : 1;
   localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_LEN - 1);

   logic              sync0, sync1;
   logic              deb_level;
   logic [DEB_W-1:0]  deb_cnt;
   logic              deb_differ, deb_accept, btn_rise;

   logic [SCAN_W-1:0] scan_cnt;
   logic              tick;
   logic [2:0]        idx, idx_next;
   logic [31:0]       shadow, shadow_next, src;
   logic [3:0]        nibble;
   logic [7:0]        an_next;
   logic [6:0]        seg_next;
   logic              dp_next;

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0:    hex_glyph = 7'b1000000;
         4'h1:    hex_glyph = 7'b1111001;
         4'h2:    hex_glyph = 7'b0100100;
         4'h3:    hex_glyph = 7'b0110000;
         4'h4:    hex_glyph = 7'b0011001;
         4'h5:    hex_glyph = 7'b0010010;
         4'h6:    hex_glyph = 7'b0000010;
         4'h7:    hex_glyph = 7'b1111000;
         4'h8:    hex_glyph = 7'b0000000;
         4'h9:    hex_glyph = 7'b0010000;
         4'hA:    hex_glyph = 7'b0001000;
         4'hB:    hex_glyph = 7'b0000011;
         4'hC:    hex_glyph = 7'b1000110;
         4'hD:    hex_glyph = 7'b0100001;
         4'hE:    hex_glyph = 7'b0000110;
         default: hex_glyph = 7'b0001110;
      endcase
   endfunction

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
      end else begin
         sync0 <= BtnMode;
         sync1 <= sync0;
      end
   end

   // A new level is accepted only after DEB_LEN consecutive differing cycles.
   assign deb_differ = (sync1 != deb_level);
   assign deb_accept = deb_differ && (deb_cnt == DEB_MAX);
   assign btn_rise   = deb_accept && sync1;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         deb_level <= 1'b0;
         deb_cnt   <= '0;
      end else if (!deb_differ || deb_accept) begin
         deb_level <= deb_accept ? sync1 : deb_level;
         deb_cnt   <= '0;
      end else begin
         deb_cnt   <= deb_cnt + DEB_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)        Mode <= 2'd0;
      else if (btn_rise) Mode <= Mode + 2'd1;
   end

   always_comb begin
      case (Mode)
         2'd0:    src = PC;
         2'd1:    src = Instr;
         2'd2:    src = DispRegData;
         default: src = DispMemData;
      endcase
   end

   assign tick = (scan_cnt == SCAN_MAX);

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)    scan_cnt <= '0;
      else if (tick) scan_cnt <= '0;
      else           scan_cnt <= scan_cnt + SCAN_W'(1);
   end

   // Outputs are derived from the post-update index and shadow so the new digit
   // appears on the same edge the index advances; shadow reloads only on the 7->0 wrap.
   always_comb begin
      idx_next    = idx + 3'd1;
      shadow_next = (idx == 3'd7) ? src : shadow;
      nibble      = shadow_next[{idx_next, 2'b00} +: 4];
      an_next     = ~(8'b0000_0001 << idx_next);
      seg_next    = hex_glyph(nibble);
      dp_next     = !(!idx_next[2] && Stat[idx_next[1:0]]);
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         idx    <= 3'd7;
         shadow <= 32'd0;
         AN     <= 8'hFF;
         SEG    <= 7'h7F;
         DP     <= 1'b1;
      end else if (tick) begin
         idx    <= idx_next;
         shadow <= shadow_next;
         AN     <= an_next;
         SEG    <= seg_next;
         DP     <= dp_next;
      end
   end

endmodule
